// File: rtl/mutex_lock_sequencer_if.sv
// ----------------------------------------------------------------------------
// mutex_lock_sequencer_if
// Avalon-MM style bus between the lock sequencer (master) and the hardware
// mutex slave s1 port.
//   m_address     master->slave  0 = mutex register, 1 = reset register
//   m_chipselect  master->slave  slave select, high with every strobe
//   m_write       master->slave  single-cycle write strobe
//   m_read        master->slave  single-cycle read strobe
//   m_writedata   master->slave  {owner[15:0], value[15:0]}
//   m_readdata    slave->master  {owner[15:0], value[15:0]}, valid
//                                combinationally during the read cycle
// ----------------------------------------------------------------------------
interface mutex_lock_sequencer_if;
  logic        m_address;
  logic        m_chipselect;
  logic        m_write;
  logic        m_read;
  logic [31:0] m_writedata;
  logic [31:0] m_readdata;

  modport master (
    output m_address,
    output m_chipselect,
    output m_write,
    output m_read,
    output m_writedata,
    input  m_readdata
  );

  modport slave (
    input  m_address,
    input  m_chipselect,
    input  m_write,
    input  m_read,
    input  m_writedata,
    output m_readdata
  );
endinterface

// File: rtl/mutex_lock_sequencer.sv
// ----------------------------------------------------------------------------
// mutex_lock_sequencer
// Acquires and releases a single hardware mutex on behalf of NUM_REQ local
// requesters. Requesters are served round-robin; each acquisition is a lock
// write followed by a readback that confirms ownership. A failed readback
// (another master owns the mutex) counts a failure and backs off for
// BACKOFF_CYCLES idle cycles before arbitration runs again.
// Ports:
//   clk       in   system clock
//   reset_n   in   synchronous active-low reset
//   req       in   level request per requester
//   rel       in   release pulse from the granted requester
//   grant     out  one-hot, high while that requester owns the mutex
//   busy      out  sequencer not idle
//   fail_cnt  out  saturating count of failed acquire attempts
//   bus       master side of the mutex slave bus
// ----------------------------------------------------------------------------
module mutex_lock_sequencer #(
  parameter int          NUM_REQ        = 4,
  parameter logic [15:0] OWNER_BASE     = 16'h0010,
  parameter logic [15:0] LOCK_VALUE     = 16'h0001,
  parameter int          BACKOFF_CYCLES = 8
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [NUM_REQ-1:0]   req,
  input  logic [NUM_REQ-1:0]   rel,
  output logic [NUM_REQ-1:0]   grant,
  output logic                 busy,
  output logic [7:0]           fail_cnt,
  mutex_lock_sequencer_if.master bus
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  // Counter only ever holds BACKOFF_CYCLES-1 down to 0.
  localparam int BO_W  = (BACKOFF_CYCLES > 1) ? $clog2(BACKOFF_CYCLES) : 1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WR_LOCK,
    ST_RD_CHECK,
    ST_HELD,
    ST_WR_REL,
    ST_BACKOFF
  } state_t;

  state_t            state_reg;
  logic [PTR_W-1:0]  sel_reg;
  logic [PTR_W-1:0]  rr_ptr_reg;
  logic [BO_W-1:0]   bo_cnt_reg;

  // Request vector rotated so that entry 0 is the requester at rr_ptr.
  logic [PTR_W-1:0]   rot_idx [NUM_REQ];
  logic [NUM_REQ-1:0] rot_req;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_rot
      assign rot_idx[gi] = PTR_W'((int'(rr_ptr_reg) + gi) % NUM_REQ);
      assign rot_req[gi] = req[rot_idx[gi]];
    end
  endgenerate

  // First set request at or after rr_ptr; scanning downwards lets the
  // lowest rotated position win.
  logic             pick_found;
  logic [PTR_W-1:0] pick_idx;

  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (rot_req[k]) begin
        pick_found = 1'b1;
        pick_idx   = rot_idx[k];
      end
    end
  end

  logic [15:0]      owner_id;
  logic [15:0]      pick_owner;
  logic [31:0]      lock_word;
  logic [31:0]      rel_word;
  logic [PTR_W-1:0] sel_plus_one;

  assign owner_id     = OWNER_BASE + 16'(sel_reg);
  assign pick_owner   = OWNER_BASE + 16'(pick_idx);
  assign lock_word    = {owner_id, LOCK_VALUE};
  assign rel_word     = {owner_id, 16'h0000};
  assign sel_plus_one = (sel_reg == PTR_W'(NUM_REQ - 1)) ? '0 : sel_reg + 1'b1;

  // The reset register of the slave is never addressed.
  assign bus.m_address = 1'b0;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_reg        <= ST_IDLE;
      sel_reg          <= '0;
      rr_ptr_reg       <= '0;
      bo_cnt_reg       <= '0;
      grant            <= '0;
      busy             <= 1'b0;
      fail_cnt         <= 8'h00;
      bus.m_chipselect <= 1'b0;
      bus.m_write      <= 1'b0;
      bus.m_read       <= 1'b0;
      bus.m_writedata  <= 32'h0;
    end else begin
      // Strobes are single-cycle: low unless the branch below raises them.
      bus.m_chipselect <= 1'b0;
      bus.m_write      <= 1'b0;
      bus.m_read       <= 1'b0;
      bus.m_writedata  <= 32'h0;

      case (state_reg)
        ST_IDLE: begin
          if (pick_found) begin
            sel_reg          <= pick_idx;
            state_reg        <= ST_WR_LOCK;
            busy             <= 1'b1;
            bus.m_chipselect <= 1'b1;
            bus.m_write      <= 1'b1;
            bus.m_writedata  <= {pick_owner, LOCK_VALUE};
          end
        end

        ST_WR_LOCK: begin
          state_reg        <= ST_RD_CHECK;
          bus.m_chipselect <= 1'b1;
          bus.m_read       <= 1'b1;
        end

        ST_RD_CHECK: begin
          if (bus.m_readdata == lock_word) begin
            if (req[sel_reg]) begin
              state_reg <= ST_HELD;
              grant     <= NUM_REQ'(1) << sel_reg;
            end else begin
              // Requester gave up while we were acquiring: hand the mutex
              // straight back without ever granting.
              state_reg        <= ST_WR_REL;
              bus.m_chipselect <= 1'b1;
              bus.m_write      <= 1'b1;
              bus.m_writedata  <= rel_word;
            end
          end else begin
            if (fail_cnt != 8'hFF) begin
              fail_cnt <= fail_cnt + 8'd1;
            end
            bo_cnt_reg <= BO_W'(BACKOFF_CYCLES - 1);
            state_reg  <= ST_BACKOFF;
          end
        end

        ST_HELD: begin
          if (rel[sel_reg] || !req[sel_reg]) begin
            grant            <= '0;
            state_reg        <= ST_WR_REL;
            bus.m_chipselect <= 1'b1;
            bus.m_write      <= 1'b1;
            bus.m_writedata  <= rel_word;
          end
        end

        ST_WR_REL: begin
          rr_ptr_reg <= sel_plus_one;
          state_reg  <= ST_IDLE;
          busy       <= 1'b0;
        end

        ST_BACKOFF: begin
          // rr_ptr untouched so the same requester retries first.
          if (bo_cnt_reg == '0) begin
            state_reg <= ST_IDLE;
            busy      <= 1'b0;
          end else begin
            bo_cnt_reg <= bo_cnt_reg - 1'b1;
          end
        end

        default: begin
          state_reg <= ST_IDLE;
          busy      <= 1'b0;
          grant     <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mutex_lock_sequencer.sv
// ----------------------------------------------------------------------------
// tb_mutex_lock_sequencer
// Directed scenarios plus a randomized round-robin phase. A behavioural
// mutex slave (take if free or same owner) answers the bus; an external
// master can seize or free it. Expected grants come from a pointer/mask
// arbitration model, expected words from the owner-ID arithmetic.
// ----------------------------------------------------------------------------
module tb_mutex_lock_sequencer;
  localparam int N  = 4;
  localparam int BO = 8;

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic [N-1:0] req = '0;
  logic [N-1:0] rel = '0;
  logic [N-1:0] grant;
  logic         busy;
  logic [7:0]   fail_cnt;

  mutex_lock_sequencer_if bus ();

  mutex_lock_sequencer #(
    .NUM_REQ(N), .OWNER_BASE(16'h0010), .LOCK_VALUE(16'h0001), .BACKOFF_CYCLES(BO)
  ) dut (
    .clk(clk), .reset_n(reset_n), .req(req), .rel(rel),
    .grant(grant), .busy(busy), .fail_cnt(fail_cnt), .bus(bus.master)
  );

  always #5 clk = ~clk;

  // Behavioural mutex slave and an external master that can seize it.
  logic [31:0] mx = 32'h0;
  logic        ext_take = 1'b0;
  logic        ext_free = 1'b0;
  int          wr_count = 0;
  int          rd_count = 0;

  assign bus.m_readdata = mx;

  always @(posedge clk) begin
    if (!reset_n) begin
      mx <= 32'h0;
    end else if (ext_take) begin
      mx <= 32'h00AA_0001;
    end else if (ext_free) begin
      mx <= 32'h0;
    end else if (bus.m_chipselect && bus.m_write) begin
      if (mx[15:0] == 16'h0 || mx[31:16] == bus.m_writedata[31:16])
        mx <= bus.m_writedata;
    end
    if (bus.m_chipselect && bus.m_write) wr_count <= wr_count + 1;
    if (bus.m_chipselect && bus.m_read)  rd_count <= rd_count + 1;
  end

  int tests = 0;
  int fails = 0;
  int ptr_m = 0;   // model round-robin pointer
  int fail_m = 0;  // model failure count

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    logic ok;
    @(posedge clk);
    #1;
    ok = !(bus.m_write && bus.m_read) &&
         (!(bus.m_write || bus.m_read) || bus.m_chipselect) &&
         ($countones(grant) <= 1) && (bus.m_address == 1'b0);
    check("bus_rules", {31'h0, ok}, 32'h1);
  endtask

  function automatic int pick(input logic [N-1:0] m, input int p);
    for (int k = 0; k < N; k++)
      if (m[(p + k) % N]) return (p + k) % N;
    return -1;
  endfunction

  function automatic logic [31:0] lock_w(input int idx);
    return {16'(16'h0010 + idx), 16'h0001};
  endfunction

  function automatic logic [31:0] rel_w(input int idx);
    return {16'(16'h0010 + idx), 16'h0000};
  endfunction

  function automatic logic [N-1:0] onehot(input int idx);
    logic [N-1:0] v;
    v = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

  task automatic do_reset();
    reset_n = 1'b0; req = '0; rel = '0; ext_take = 1'b0; ext_free = 1'b0;
    tick(); tick();
    reset_n = 1'b1;
    ptr_m = 0; fail_m = 0;
  endtask

  // Ticks until a write strobe, then checks its data.
  task automatic wait_write(input string tag, input logic [31:0] exp_word);
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (bus.m_chipselect && bus.m_write) begin
        seen = 1'b1;
        break;
      end
    end
    check({tag, "_seen"}, {31'h0, seen}, 32'h1);
    if (seen) check(tag, bus.m_writedata, exp_word);
  endtask

  task automatic wait_grant(output logic [N-1:0] g);
    g = '0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (grant != '0) begin
        g = grant;
        break;
      end
    end
    check("grant_seen", {31'h0, (g != '0)}, 32'h1);
  endtask

  initial begin
    logic [N-1:0] g, mask;
    int exp, hold, w0, base, last_rd, n;
    bit cont, ab;

    // T0 reset state
    reset_n = 1'b0;
    tick(); tick();
    check("rst_grant", 32'(grant), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_fail", 32'(fail_cnt), 32'h0);
    check("rst_bus", {29'h0, bus.m_chipselect, bus.m_write, bus.m_read}, 32'h0);
    check("rst_wdata", bus.m_writedata, 32'h0);
    reset_n = 1'b1;
    $display("[TB] T0 reset state checked");

    // T1 single requester, free mutex
    req = 4'b0010;                                   // c0
    tick();                                          // c1
    check("t1_wr", {30'h0, bus.m_chipselect, bus.m_write}, 32'h3);
    check("t1_wdata", bus.m_writedata, 32'h0011_0001);
    check("t1_busy", 32'(busy), 32'h1);
    tick();                                          // c2
    check("t1_rd", {30'h0, bus.m_chipselect, bus.m_read}, 32'h3);
    tick();                                          // c3
    check("t1_grant", 32'(grant), 32'h2);
    tick(); tick();                                  // c5
    rel = 4'b0010;
    tick();                                          // c6
    rel = '0; req = '0;
    check("t1_grant_low", 32'(grant), 32'h0);
    check("t1_relw", {31'h0, bus.m_write}, 32'h1);
    check("t1_rel_wdata", bus.m_writedata, 32'h0011_0000);
    tick();                                          // c7
    check("t1_idle", 32'(busy), 32'h0);
    $display("[TB] T1 single requester done");

    // T2 round robin, all requesting
    do_reset();
    req = 4'b1111;
    for (int r = 0; r < 5; r++) begin
      exp = pick(req, ptr_m);
      wait_grant(g);
      check("t2_order", 32'(g), 32'(onehot(exp)));
      tick(); tick();
      rel = g;
      tick();
      rel = '0;
      if (r == 4) req = '0;
      check("t2_rel_wdata", bus.m_writedata, rel_w(exp));
      ptr_m = (exp + 1) % N;
      $display("[TB] T2 round %0d grant=%b", r, g);
    end
    tick();

    // T3 contention with an external owner
    ext_take = 1'b1; req = 4'b0001;                  // c0
    tick();                                          // c1
    ext_take = 1'b0;
    check("t3_lock_wdata", bus.m_writedata, 32'h0010_0001);
    tick();                                          // c2
    check("t3_rd", 32'(bus.m_read), 32'h1);
    tick();                                          // c3
    fail_m++;
    check("t3_fail", 32'(fail_cnt), 32'(fail_m));
    check("t3_bo_quiet", 32'(bus.m_chipselect), 32'h0);
    ext_free = 1'b1;
    for (int i = 0; i < BO - 1; i++) begin           // c4..c10
      tick();
      ext_free = 1'b0;
      check("t3_bo_quiet", 32'(bus.m_chipselect), 32'h0);
      check("t3_bo_busy", 32'(busy), 32'h1);
    end
    tick();                                          // c11
    check("t3_idle_gap", {31'h0, bus.m_chipselect}, 32'h0);
    check("t3_idle_busy", 32'(busy), 32'h0);
    tick();                                          // c12
    check("t3_retry_wr", 32'(bus.m_write), 32'h1);
    check("t3_retry_wdata", bus.m_writedata, 32'h0010_0001);
    tick(); tick();                                  // c14
    check("t3_grant", 32'(grant), 32'h1);
    check("t3_fail_hold", 32'(fail_cnt), 32'(fail_m));
    rel = 4'b0001;
    tick();
    rel = '0; req = '0;
    check("t3_rel_wdata", bus.m_writedata, 32'h0010_0000);
    ptr_m = 1;
    tick();
    $display("[TB] T3 contention done fail_cnt=%0d", fail_cnt);

    // T4 abandon during WR_LOCK
    req = 4'b0100;
    tick();
    check("t4_lock_wdata", bus.m_writedata, 32'h0012_0001);
    req = '0;
    tick();
    tick();
    check("t4_no_grant", 32'(grant), 32'h0);
    check("t4_relw", 32'(bus.m_write), 32'h1);
    check("t4_rel_wdata", bus.m_writedata, 32'h0012_0000);
    tick();
    check("t4_idle", 32'(busy), 32'h0);
    $display("[TB] T4 abandon done");

    // T5 reset while held
    req = 4'b0001;
    tick(); tick(); tick();
    check("t5_grant", 32'(grant), 32'h1);
    check("t5_fail_pre", 32'(fail_cnt), 32'(fail_m));
    w0 = wr_count;
    reset_n = 1'b0;
    tick();
    check("t5_grant_rst", 32'(grant), 32'h0);
    check("t5_busy_rst", 32'(busy), 32'h0);
    check("t5_fail_rst", 32'(fail_cnt), 32'h0);
    reset_n = 1'b1; req = '0;
    tick(); tick(); tick();
    check("t5_no_relw", 32'(wr_count - w0), 32'h0);
    $display("[TB] T5 reset mid-held done");

    // Randomized rounds
    do_reset();
    for (int r = 0; r < 40; r++) begin
      mask = N'($urandom_range(1, (1 << N) - 1));
      exp  = pick(mask, ptr_m);
      cont = ($urandom_range(0, 3) == 0);
      ab   = ($urandom_range(0, 4) == 0);
      req  = mask;
      if (cont) ext_take = 1'b1;
      wait_write("rnd_lock", lock_w(exp));
      ext_take = 1'b0;
      if (cont) begin
        tick(); tick();
        fail_m = (fail_m < 255) ? fail_m + 1 : 255;
        check("rnd_fail", 32'(fail_cnt), 32'(fail_m));
        ext_free = 1'b1;
        tick();
        ext_free = 1'b0;
        wait_write("rnd_retry", lock_w(exp));
      end
      if (ab) begin
        req[exp] = 1'b0;
        tick(); tick();
        check("rnd_ab_grant", 32'(grant), 32'h0);
        check("rnd_ab_rel", bus.m_writedata, rel_w(exp));
      end else begin
        tick(); tick();
        check("rnd_grant", 32'(grant), 32'(onehot(exp)));
        hold = $urandom_range(0, 3);
        for (int h = 0; h < hold; h++) begin
          rel = N'($urandom) & ~onehot(exp);
          tick();
          check("rnd_hold", 32'(grant), 32'(onehot(exp)));
        end
        if ($urandom_range(0, 1) == 1) rel = onehot(exp) | (N'($urandom) & ~onehot(exp));
        else begin
          rel = N'($urandom) & ~onehot(exp);
          req[exp] = 1'b0;
        end
        tick();
        rel = '0;
        check("rnd_grant_low", 32'(grant), 32'h0);
        check("rnd_rel", bus.m_writedata, rel_w(exp));
      end
      ptr_m = (exp + 1) % N;
      $display("[TB] rnd %0d mask=%b winner=%0d cont=%0d abandon=%0d", r, mask, exp, cont, ab);
      req = '0;
    end
    tick(); tick();

    // T6 saturation of the failure counter
    do_reset();
    ext_take = 1'b1; req = 4'b0001;
    tick();
    ext_take = 1'b0;
    base = rd_count; last_rd = rd_count;
    for (int i = 0; i < 6000 && (rd_count - base) < 300; i++) begin
      tick();
      if (rd_count != last_rd) begin
        tick();
        n = rd_count - base;
        check("t6_count", 32'(fail_cnt), 32'((n < 255) ? n : 255));
        last_rd = rd_count;
      end
    end
    check("t6_attempts", 32'(rd_count - base), 32'd300);
    check("t6_sat", 32'(fail_cnt), 32'hFF);
    $display("[TB] T6 saturation fail_cnt=%h after %0d attempts", fail_cnt, rd_count - base);
    do_reset();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
